accel_spi_responder: RTL and testbench
======================================

Name: accel_spi_responder

Overview:
- Synthesizable 3-wire SPI slave that emulates the accelerometer's register interface. It is the responder end of the accelerometer SPI link that the NIOS system drives as master.
- Used in simulation and for hardware-in-loop bring-up of the accelerometer SPI path without a physical sensor.
- Provides a 64x8 register file, injected X/Y/Z samples, a coherent burst-read buffer and a DATA_READY interrupt.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/sdio input (min 2)
- DEVID, 8'hE5, read-only value at address 0x00

Ports:
- clk_clk  input  1  system clock; SCLK half-period must be >= SYNC_STAGES+2 clk_clk periods
- reset_reset_n  input  1  reset, asynchronous assert, active-low
- spi_sclk  input  1  SPI clock from master, mode 3 (idle high)
- spi_cs_n  input  1  chip select, active-low
- spi_sdio_in  input  1  SDIO pad input
- spi_sdio_out  output  1  SDIO drive value
- spi_sdio_oe  output  1  SDIO tri-state enable, 1 = responder drives
- sample_x  input  16  injected X sample (two's complement)
- sample_y  input  16  injected Y sample
- sample_z  input  16  injected Z sample
- sample_valid  input  1  one-cycle strobe that captures sample_x/y/z
- int_out  output  1  interrupt to master (G_SENSOR_INT)

Behaviour:
- Reset (async, reset_reset_n=0):
  - Outputs: spi_sdio_oe=0, spi_sdio_out=1, int_out=0.
  - State goes to IDLE. All registers clear to 0 except 0x00=DEVID.
  - Pending buffer is cleared and its flag is cleared.
  - Reset mid-transfer aborts immediately with no write.
- Input synchronization:
  - sclk, cs_n and sdio_in each pass through SYNC_STAGES flops.
  - Rise/fall edge detects are taken on the synchronized sclk and cs_n.
- Frame format:
  - Command byte, MSB first: bit7 RW (1=read), bit6 MB (multi-byte), bits5:0 address.
  - Then data bytes, MSB first.
- Edge usage: bits are sampled on synced sclk rise and driven on synced sclk fall.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD on synced cs_n fall; bit counter=0.
  - CMD: shift in 8 bits. On the 8th rise, latch RW/MB/addr, then go to RDATA if RW=1, otherwise WDATA.
  - WDATA: shift in 8 bits. On the 8th rise, write reg[addr] unless addr is read-only; read-only writes are silently dropped. Then advance addr and stay in WDATA.
  - RDATA: on the first sclk fall after the command, load shifter with reg[addr], assert oe and drive the MSB. Each later fall drives the next bit. After the 8th bit, the next fall loads the next byte.
  - Any state -> IDLE on synced cs_n rise: oe=0 in the same cycle, partial byte discarded, no write.
- Address advance after each byte:
  - MB=1: addr+1, wrapping 0x3F->0x00.
  - MB=0: addr unchanged.
- Read-only addresses: 0x00, 0x30 (INT_SOURCE), 0x32-0x37 (DATAX0..DATAZ1), 0x39.
- Unimplemented addresses read back what was last written.
- Sample capture:
  - sample_valid latches {z,y,x} into the pending buffer and sets the pending flag.
  - While synced cs_n is high and pending=1:
    - Copy pending into 0x32..0x37, little-endian: 0x32=x[7:0], 0x33=x[15:8], ..., 0x37=z[15:8].
    - Set INT_SOURCE bit7 (DATA_READY) and clear pending.
  - This copy is one cycle, so burst reads stay coherent.
  - If a new sample_valid arrives in the same cycle as the transfer, the new sample overwrites pending and the flag stays set.
- DATA_READY clear: cleared when a read loads any address 0x32..0x37.
- Interrupt: int_out registered = |(INT_SOURCE & INT_ENABLE[0x2E]). It is one cycle after the source change.
- Latency:
  - synced sclk fall -> sdio_out update: SYNC_STAGES+1 clk.
  - cs_n rise -> oe=0: SYNC_STAGES+1 clk.
- Glitch rule: an sclk edge seen while synced cs_n is high is ignored.

Decomposition:
- accel_spi_pkg holds:
  - address constants: DEVID_ADDR, INT_ENABLE_ADDR=0x2E, INT_SOURCE_ADDR=0x30, DATAX0_ADDR=0x32
  - the 64-bit read-only mask
  - the FSM state enum
- One sub-module, spi_edge_sync, is the SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated for sclk and cs_n; sdio uses the synchronizer only.

Test Plan:
- Read DEVID: cmd 0x80 then 8 clocks -> returns 0xE5; oe=0 during the command, 1 during the data byte, 0 after cs_n rise.
- Write/readback: cmd 0x2D + 0x08, then cmd 0xAD -> returns 0x08. Write 0x55 to 0x00 -> reads back 0xE5.
- Burst sample read: x=0x0123, y=0xFF80, z=0x00FA with valid while cs_n high; INT_ENABLE=0x80 -> int_out=1. Cmd 0xF2 + 6 bytes -> 23 01 80 FF FA 00; int_out=0 after the first data load.
- Coherency: sample x=0x1111 pulsed after the 2nd byte of a burst -> the burst still returns the old values. Next burst after cs_n high -> 0x32=0x11, 0x33=0x11.
- Abort: cmd 0x2D + 4 data bits, then cs_n high -> reg 0x2D unchanged; oe=0 within SYNC_STAGES+1 clk.
- Wrap/reset: MB read from 0x3F for 2 bytes -> reg[0x3F], then 0xE5. Assert reset mid-read -> oe=0 immediately and registers at defaults.

Source files
------------

// File: rtl/accel_spi_pkg.sv
// Shared constants, command layout and FSM encoding for the accelerometer SPI responder.
package accel_spi_pkg;

    localparam logic [5:0] DEVID_ADDR      = 6'h00;
    localparam logic [5:0] INT_ENABLE_ADDR = 6'h2E;
    localparam logic [5:0] INT_SOURCE_ADDR = 6'h30;
    localparam logic [5:0] DATAX0_ADDR     = 6'h32;

    // DEVID, INT_SOURCE, DATAX0..DATAZ1 and 0x39 ignore master writes
    localparam logic [63:0] RO_MASK = (64'h1  << DEVID_ADDR)
                                    | (64'h1  << INT_SOURCE_ADDR)
                                    | (64'h3F << DATAX0_ADDR)
                                    | (64'h1  << 6'h39);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} spi_state_e;

    typedef struct packed {
        logic       rw;
        logic       mb;
        logic [5:0] addr;
    } spi_cmd_t;

    function automatic logic is_data_addr(input logic [5:0] a);
        return (a >= DATAX0_ADDR) && (a <= DATAX0_ADDR + 6'd5);
    endfunction

endpackage

// File: rtl/accel_spi_responder_if.sv
// 3-wire SPI pad bundle between the bus master and the responder.
interface accel_spi_responder_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_sdio_in;
    logic spi_sdio_out;
    logic spi_sdio_oe;

    modport master (output spi_sclk, spi_cs_n, spi_sdio_in,
                    input  spi_sdio_out, spi_sdio_oe);
    modport slave  (input  spi_sclk, spi_cs_n, spi_sdio_in,
                    output spi_sdio_out, spi_sdio_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_edge_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise =  sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] &  prev_q;
endmodule

// File: rtl/accel_spi_responder.sv
// Mode-3 3-wire SPI slave emulating the accelerometer register map with injected samples.
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hE5
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    accel_spi_responder_if.slave  spi,
    input  logic [15:0]           sample_x,
    input  logic [15:0]           sample_y,
    input  logic [15:0]           sample_z,
    input  logic                  sample_valid,
    output logic                  int_out
);
    spi_state_e          state, state_nxt;
    spi_cmd_t            cmd_in;
    logic [SYNC_STAGES-1:0] sdio_sync;
    logic                sdio_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [2:0]          bit_cnt;
    logic [6:0]          shifter;
    logic [7:0]          shift_in_word, rd_byte;
    logic [5:0]          cur_addr, addr_nxt;
    logic                mb_q, sdio_out_q, oe_q;
    logic [63:0][7:0]    regs;
    logic [47:0]         pend_buf;
    logic                pend, cs_idle, copy_smp;
    logic                shift_rx, cmd_done, wr_byte, rd_load, rd_shift;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sclk_sync (
        .clk(clk_clk), .rst_n(reset_reset_n), .d(spi.spi_sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk(clk_clk), .rst_n(reset_reset_n), .d(spi.spi_cs_n), .rise(cs_rise), .fall(cs_fall));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) sdio_sync <= '1;
        else                sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi.spi_sdio_in};
    end

    assign sdio_s        = sdio_sync[SYNC_STAGES-1];
    assign shift_in_word = {shifter, sdio_s};
    assign cmd_in        = spi_cmd_t'(shift_in_word);
    assign rd_byte       = regs[cur_addr];
    assign addr_nxt      = mb_q ? cur_addr + 6'd1 : cur_addr;
    // IDLE tracks synced cs_n high, so sclk edges outside a frame never reach the shifter
    assign cs_idle       = (state == IDLE);
    assign copy_smp      = cs_idle && pend;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_rx  = 1'b0;
        cmd_done  = 1'b0;
        wr_byte   = 1'b0;
        rd_load   = 1'b0;
        rd_shift  = 1'b0;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_nxt = CMD;
                CMD: if (sclk_rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        cmd_done  = 1'b1;
                        state_nxt = cmd_in.rw ? RDATA : WDATA;
                    end
                end
                WDATA: if (sclk_rise) begin
                    shift_rx = 1'b1;
                    wr_byte  = (bit_cnt == 3'd7);
                end
                RDATA: if (sclk_fall) begin
                    rd_load  = (bit_cnt == 3'd0);
                    rd_shift = (bit_cnt != 3'd0);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt    <= '0;
            shifter    <= '0;
            cur_addr   <= '0;
            mb_q       <= 1'b0;
            sdio_out_q <= 1'b1;
            oe_q       <= 1'b0;
            regs       <= '0;
            regs[DEVID_ADDR] <= DEVID;
            pend_buf   <= '0;
            pend       <= 1'b0;
            int_out    <= 1'b0;
        end else begin
            if (cs_rise) begin
                oe_q    <= 1'b0;
                bit_cnt <= '0;
            end else if (cs_idle && cs_fall) begin
                bit_cnt <= '0;
            end else if (shift_rx) begin
                shifter <= shift_in_word[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end else if (rd_load) begin
                shifter    <= rd_byte[6:0];
                sdio_out_q <= rd_byte[7];
                oe_q       <= 1'b1;
                bit_cnt    <= 3'd1;
            end else if (rd_shift) begin
                sdio_out_q <= shifter[6];
                shifter    <= {shifter[5:0], 1'b0};
                bit_cnt    <= bit_cnt + 3'd1;
            end

            if (cmd_done) begin
                cur_addr <= cmd_in.addr;
                mb_q     <= cmd_in.mb;
            end
            if (wr_byte) begin
                if (!RO_MASK[cur_addr]) regs[cur_addr] <= shift_in_word;
                cur_addr <= addr_nxt;
            end
            if (rd_load) begin
                cur_addr <= addr_nxt;
                if (is_data_addr(cur_addr)) regs[INT_SOURCE_ADDR][7] <= 1'b0;
            end
            // Whole sample lands in one cycle, only between frames, so bursts stay coherent
            if (copy_smp) begin
                regs[DATAX0_ADDR +: 6]   <= pend_buf;
                regs[INT_SOURCE_ADDR][7] <= 1'b1;
            end

            if (sample_valid) begin
                pend_buf <= {sample_z, sample_y, sample_x};
                pend     <= 1'b1;
            end else if (copy_smp) begin
                pend     <= 1'b0;
            end

            int_out <= |(regs[INT_SOURCE_ADDR] & regs[INT_ENABLE_ADDR]);
        end
    end

    assign spi.spi_sdio_out = sdio_out_q;
    assign spi.spi_sdio_oe  = oe_q;
endmodule

// File: tb/tb_accel_spi_responder.sv
// Self-checking bench: SPI master tasks, register-map model, directed plus random traffic.
module tb_accel_spi_responder;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sx = '0, sy = '0, sz = '0;
    logic        sv = 1'b0;
    logic        int_o;

    accel_spi_responder_if spi_bus();

    accel_spi_responder #(.SYNC_STAGES(SYNC), .DEVID(8'hE5)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .spi(spi_bus),
        .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(sv),
        .int_out(int_o));

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  m [64];
    logic        mpend;
    logic [47:0] mbuf;
    logic [7:0]  last_rd [8];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    function automatic logic ro(input logic [5:0] a);
        return a == 6'h00 || a == 6'h30 || (a >= 6'h32 && a <= 6'h37) || a == 6'h39;
    endfunction

    function automatic logic model_int();
        return |(m[6'h30] & m[6'h2E]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        m[0] = 8'hE5;
        mpend = 1'b0;
        mbuf = '0;
    endtask

    task automatic apply_pend();
        if (mpend) begin
            for (int i = 0; i < 6; i++) m[6'h32 + i] = mbuf[8*i +: 8];
            m[6'h30][7] = 1'b1;
            mpend = 1'b0;
        end
    endtask

    task automatic bit_x(input logic b, output logic rb, output logic roe);
        @(negedge clk);
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_sdio_in = b;
        repeat (HALF - 1) @(negedge clk);
        rb  = spi_bus.spi_sdio_out;
        roe = spi_bus.spi_sdio_oe;
        @(negedge clk);
        spi_bus.spi_sclk = 1'b1;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic byte_x(input logic [7:0] wb, output logic [7:0] rb, output logic [7:0] ob);
        logic b, o;
        for (int i = 7; i >= 0; i--) begin
            bit_x(wb[i], b, o);
            rb[i] = b;
            ob[i] = o;
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        spi_bus.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        @(negedge clk);
        spi_bus.spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        apply_pend();
        chk("int_after_frame", int_o, model_int());
    endtask

    task automatic inject(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sx = x; sy = y; sz = z; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        mbuf = {z, y, x};
        mpend = 1'b1;
        if (spi_bus.spi_cs_n) begin
            repeat (4) @(negedge clk);
            apply_pend();
            chk("int_after_sample", int_o, model_int());
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic mb, input int n, input logic [31:0] d);
        logic [7:0] rb, ob, b;
        logic [5:0] addr;
        addr = a;
        cs_lo();
        byte_x({1'b0, mb, a}, rb, ob);
        chk("wr_cmd_oe", ob, 8'h00);
        for (int k = 0; k < n; k++) begin
            b = d[8*k +: 8];
            byte_x(b, rb, ob);
            if (!ro(addr)) m[addr] = b;
            addr = mb ? addr + 6'd1 : addr;
        end
        cs_hi();
    endtask

    task automatic rd(input logic [5:0] a, input logic mb, input int n,
                      input int inj_after, input logic [15:0] ix);
        logic [7:0] rb, ob, exp;
        logic [5:0] addr;
        addr = a;
        cs_lo();
        byte_x({1'b1, mb, a}, rb, ob);
        chk("rd_cmd_oe", ob, 8'h00);
        for (int k = 0; k < n; k++) begin
            exp = m[addr];
            if (addr >= 6'h32 && addr <= 6'h37) m[6'h30][7] = 1'b0;
            byte_x(8'hFF, rb, ob);
            if (k < 8) last_rd[k] = rb;
            chk($sformatf("rd_data@%02h", addr), rb, exp);
            chk("rd_data_oe", ob, 8'hFF);
            if (k == 0) chk("int_after_load", int_o, model_int());
            addr = mb ? addr + 6'd1 : addr;
            if (k == inj_after) inject(ix, sy, sz);
        end
        cs_hi();
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0] rb, ob;
        logic       b, o;
        spi_bus.spi_sclk = 1'b1;
        spi_bus.spi_cs_n = 1'b1;
        spi_bus.spi_sdio_in = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_oe", spi_bus.spi_sdio_oe, 1'b0);
        chk("rst_out", spi_bus.spi_sdio_out, 1'b1);
        chk("rst_int", int_o, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // DEVID, write/readback, read-only write drop
        rd(6'h00, 1'b0, 1, -1, 16'h0);
        chk("devid", last_rd[0], 8'hE5);
        wr(6'h2D, 1'b0, 1, 32'h08);
        rd(6'h2D, 1'b0, 1, -1, 16'h0);
        chk("readback_2d", last_rd[0], 8'h08);
        wr(6'h00, 1'b0, 1, 32'h55);
        rd(6'h00, 1'b0, 1, -1, 16'h0);
        chk("devid_ro", last_rd[0], 8'hE5);

        // burst sample read with interrupt
        wr(6'h2E, 1'b0, 1, 32'h80);
        inject(16'h0123, 16'hFF80, 16'h00FA);
        chk("int_set", int_o, 1'b1);
        rd(6'h32, 1'b1, 6, -1, 16'h0);
        chk("burst_b0", last_rd[0], 8'h23);
        chk("burst_b3", last_rd[3], 8'hFF);
        chk("burst_b4", last_rd[4], 8'hFA);

        // coherency: new sample mid-burst stays pending until cs_n high
        rd(6'h32, 1'b1, 6, 1, 16'h1111);
        chk("coh_old_x0", last_rd[0], 8'h23);
        rd(6'h32, 1'b1, 2, -1, 16'h0);
        chk("coh_new_x0", last_rd[0], 8'h11);
        chk("coh_new_x1", last_rd[1], 8'h11);

        // write abort after 4 data bits
        cs_lo();
        byte_x(8'h2D, rb, ob);
        for (int i = 0; i < 4; i++) bit_x(1'b1, b, o);
        cs_hi();
        rd(6'h2D, 1'b0, 1, -1, 16'h0);
        chk("abort_2d", last_rd[0], 8'h08);

        // read abort: oe drops within SYNC+1 clocks of cs_n rise
        cs_lo();
        byte_x(8'h80, rb, ob);
        for (int i = 0; i < 3; i++) bit_x(1'b0, b, o);
        chk("abort_oe_before", o, 1'b1);
        @(negedge clk);
        spi_bus.spi_cs_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        chk("abort_oe_after", spi_bus.spi_sdio_oe, 1'b0);
        repeat (10) @(negedge clk);

        // address wrap 0x3F -> 0x00
        wr(6'h3F, 1'b0, 1, 32'hA7);
        rd(6'h3F, 1'b1, 2, -1, 16'h0);
        chk("wrap_3f", last_rd[0], 8'hA7);
        chk("wrap_00", last_rd[1], 8'hE5);

        // randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: wr(6'($urandom), 1'($urandom), $urandom_range(1, 3), $urandom);
                1: rd(6'($urandom), 1'($urandom), $urandom_range(1, 4), -1, 16'h0);
                2: inject(16'($urandom), 16'($urandom), 16'($urandom));
                default: wr(6'h2E, 1'b0, 1, $urandom);
            endcase
        end

        // reset mid-read
        wr(6'h2E, 1'b0, 1, 32'hFF);
        inject(16'h5A5A, 16'h0, 16'h0);
        cs_lo();
        byte_x(8'hF2, rb, ob);
        for (int i = 0; i < 3; i++) bit_x(1'b0, b, o);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", spi_bus.spi_sdio_oe, 1'b0);
        chk("midrst_out", spi_bus.spi_sdio_out, 1'b1);
        chk("midrst_int", int_o, 1'b0);
        spi_bus.spi_cs_n = 1'b1;
        spi_bus.spi_sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        rd(6'h2E, 1'b1, 2, -1, 16'h0);
        chk("postrst_2e", last_rd[0], 8'h00);
        rd(6'h32, 1'b0, 1, -1, 16'h0);
        chk("postrst_32", last_rd[0], 8'h00);
        rd(6'h00, 1'b0, 1, -1, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
